booth_mul: RTL and testbench



---
 rtl/booth_mul_if.sv | 22 ++
 rtl/booth_mul.sv | 129 ++++++++++++
 tb/tb_booth_mul.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_if.sv
// booth_mul_if: request/result bundle of the Booth multiplier.
//   start/a/b come from the requester; busy/done/hi/lo are returned by the multiplier.
//   master = requester side, slave = multiplier side.
interface booth_mul_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/booth_mul.sv
// booth_mul: sequential signed 32x32->64 multiplier, radix-4 (modified Booth), one digit per clock.
// Latency 16 clocks from the start edge to done/hi/lo (k+1 clocks with BOOTH_MUL_EARLY_TERM_EN defined).
// No backpressure: start is sampled only while busy=0 and ignored otherwise; one multiply in flight.
//
// Ports: clk, reset_n (async, active-low), bus (booth_mul_if.slave):
//   start/a/b request in; busy/done/hi/lo status and registered product out.
// Optional macro BOOTH_MUL_EARLY_TERM_EN: finish as soon as all remaining Booth digits are zero.
module booth_mul (
  input  logic         clk,
  input  logic         reset_n,
  booth_mul_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [63:0] acc;
  logic [3:0]  k;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        load;
  logic        finish;
  logic        last;
  logic [32:0] mx;
  logic [2:0]  grp;
  logic [63:0] mcand_ext;
  logic [63:0] pp_base;
  logic [63:0] pp;
  logic [63:0] acc_next;

  // Booth recoding: mx carries the implicit mplier[-1]=0 at bit 0,
  // so the group for digit k sits at mx[2k+2:2k].
  always_comb begin
    mx        = {mplier, 1'b0};
    grp       = mx[{k, 1'b0} +: 3];
    mcand_ext = {{32{mcand[31]}}, mcand};
    case (grp)
      3'b001, 3'b010: pp_base = mcand_ext;
      3'b011:         pp_base = mcand_ext << 1;
      3'b100:         pp_base = -(mcand_ext << 1);
      3'b101, 3'b110: pp_base = -mcand_ext;
      default:        pp_base = '0;
    endcase
    pp       = pp_base << {k, 1'b0};
    acc_next = acc + pp;
  end

`ifdef BOOTH_MUL_EARLY_TERM_EN
  // mplier[31:2k+1] all equal <=> arithmetic shift by 2k+1 leaves only sign copies.
  logic [31:0] rest;
  logic        rest_same;
  always_comb begin
    rest      = $signed(mplier) >>> {k, 1'b1};
    rest_same = (rest == '0) || (rest == '1);
    last      = (k == 4'd15) || rest_same;
  end
`else
  always_comb begin
    last = (k == 4'd15);
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and control strobes
  always_comb begin
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands, accumulator, digit counter, result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      k      <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        mcand  <= bus.a;
        mplier <= bus.b;
        acc    <= '0;
        k      <= '0;
      end else if (state == RUN) begin
        acc <= acc_next;
        k   <= k + 4'd1;
      end
      // hi/lo change only on completion, both words together
      if (finish) begin
        hi_q <= acc_next[63:32];
        lo_q <= acc_next[31:0];
        k    <= '0;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_booth_mul.sv
// tb_booth_mul: randomized scoreboard bench for booth_mul.
// Driver pushes the expected product and completion cycle; a negedge monitor checks busy,
// done timing and hi/lo. Directed cases cover the listed corner products, busy, reset.
module tb_booth_mul;

  logic clk;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;

  booth_mul_if bus();

  booth_mul dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [63:0] prod;
    int          start_cyc;
    int          done_cyc;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Exact signed product by plain arithmetic
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // With early exit, the multiply ends after k+1 clocks where k is the first
  // digit position such that b fits into a (2k+2)-bit signed number.
  function automatic int lat_of(input logic [31:0] y);
`ifdef BOOTH_MUL_EARLY_TERM_EN
    longint v;
    longint lim;
    v = longint'($signed(y));
    for (int kk = 0; kk < 16; kk++) begin
      lim = longint'(1) << (2 * kk + 1);
      if (v >= -lim && v < lim) return kk + 1;
    end
    return 16;
`else
    return (y === 32'hx) ? 0 : 16;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h want 0x%016h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: busy profile, done timing and product
  always @(negedge clk) begin
    if (reset_n) begin
      logic busy_exp;
      busy_exp = (q.size() > 0) && (cyc >= q[0].start_cyc) && (cyc < q[0].done_cyc);
      chk("busy", {63'd0, bus.busy}, {63'd0, busy_exp});
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", {bus.hi, bus.lo}, e.prod);
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
        end
      end else if (q.size() > 0 && cyc >= q[0].done_cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("missing_done", 64'd0, 64'd1);
      end
    end
  end

  // Drive one start pulse; record=0 issues a start that must be ignored.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit record);
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    if (record) q.push_back('{prod: model(av, bv), start_cyc: cyc + 1, done_cyc: cyc + 1 + lat_of(bv)});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("idle_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic mul_chk(input string name, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] want);
    issue(av, bv, 1'b1);
    wait_idle();
    chk(name, {bus.hi, bus.lo}, want);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'(signed'($urandom_range(0, 255)) - 128);
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'(1) << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] ra, rb;
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #2;
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;

    // Directed products
    mul_chk("p_7x6",      32'd7,          32'd6,          64'h0000_0000_0000_002A);
    mul_chk("p_m5x3",     32'hFFFF_FFFB,  32'd3,          64'hFFFF_FFFF_FFFF_FFF1);
    mul_chk("p_min_min",  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
    mul_chk("p_max_max",  32'h7FFF_FFFF,  32'h7FFF_FFFF,  64'h3FFF_FFFF_0000_0001);
    mul_chk("p_min_max",  32'h8000_0000,  32'h7FFF_FFFF,  64'hC000_0000_8000_0000);
    mul_chk("p_early3",   32'h1234_5678,  32'd3,          64'h0000_0000_369D_0368);
    mul_chk("p_zero",     32'h1234_5678,  32'd0,          64'd0);
    mul_chk("p_neg1",     32'h1234_5678,  32'hFFFF_FFFF,  64'hFFFF_FFFF_EDCB_A988);

    // Start while busy is ignored
    issue(32'd2, 32'd3, 1'b1);
    w = (lat_of(32'd3) == 16) ? 3 : 0;
    repeat (w) @(negedge clk);
    issue(32'd9, 32'd9, 1'b0);
    wait_idle();
    chk("busy_ignore", {bus.hi, bus.lo}, 64'd6);

    // Start in the done cycle is accepted
    issue(32'd11, 32'd13, 1'b1);
    repeat (lat_of(32'd13) - 1) @(negedge clk);
    issue(32'hFFFF_FFFD, 32'd17, 1'b1);
    wait_idle();
    chk("b2b_second", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFCD);

    // Reset in the middle of a long multiply
    issue(32'h0000_1234, 32'h7FFF_0001, 1'b1);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    chk("midreset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midreset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("after_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    mul_chk("after_reset_mul", 32'd5, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFDD);

    // Randomized traffic: back-to-back, gaps, ignored starts
    for (int i = 0; i < 300; i++) begin
      int lat;
      ra  = pick();
      rb  = pick();
      lat = lat_of(rb);
      issue(ra, rb, 1'b1);
      if (lat >= 4 && $urandom_range(0, 3) == 0) begin
        issue($urandom, $urandom, 1'b0);
        w = lat - 3;
      end else begin
        w = lat - 1;
      end
      if ($urandom_range(0, 1) == 1) w = w + $urandom_range(1, 3);
      repeat (w) @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
